// File: rtl/alu_pkg.sv
// Shared RV32I ALU definitions: operation codes, opcodes, funct3 values and operand selects.
// Used by decode, the ID/EX issue register and the ALU itself.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_AND    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SLT    = 4'b0101,
        ALU_SLTU   = 4'b0110,
        ALU_SLL    = 4'b0111,
        ALU_SRL    = 4'b1000,
        ALU_SRA    = 4'b1001,
        ALU_PASS_B = 4'b1010
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Integer register/immediate funct3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SEL_A_ZERO = 2'd0,
        SEL_A_RS1  = 2'd1,
        SEL_A_PC   = 2'd2
    } sel_a_t;

    typedef enum logic [1:0] {
        SEL_B_ZERO = 2'd0,
        SEL_B_RS2  = 2'd1,
        SEL_B_IMM  = 2'd2,
        SEL_B_FOUR = 2'd3
    } sel_b_t;

    // bne/bge/bgeu take the branch when the ALU condition is false
    function automatic logic branch_inverts(input logic [2:0] f3);
        return (f3 == F3_BNE) || (f3 == F3_BGE) || (f3 == F3_BGEU);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I opcode/funct decode into ALU operation, operand selects,
// branch sense inversion and an illegal-instruction flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output alu_op_t    alu_control,
    output sel_a_t     sel_a,
    output sel_b_t     sel_b,
    output logic       br_invert,
    output logic       illegal
);

    function automatic alu_op_t op_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        alu_control = ALU_ADD;
        sel_a       = SEL_A_ZERO;
        sel_b       = SEL_B_ZERO;
        br_invert   = 1'b0;
        illegal     = 1'b0;

        case (opcode)
            OPC_OP: begin
                alu_control = op_from_funct3(funct3, funct7_b5);
                sel_a       = SEL_A_RS1;
                sel_b       = SEL_B_RS2;
            end
            OPC_OP_IMM: begin
                // instruction[30] is part of the immediate for addi, so only shifts honour it
                alu_control = op_from_funct3(funct3, funct7_b5 && (funct3 == F3_SRL_SRA));
                sel_a       = SEL_A_RS1;
                sel_b       = SEL_B_IMM;
            end
            OPC_LOAD, OPC_STORE: begin
                sel_a = SEL_A_RS1;
                sel_b = SEL_B_IMM;
            end
            OPC_LUI: begin
                alu_control = ALU_PASS_B;
                sel_b       = SEL_B_IMM;
            end
            OPC_AUIPC: begin
                sel_a = SEL_A_PC;
                sel_b = SEL_B_IMM;
            end
            OPC_JAL, OPC_JALR: begin
                sel_a = SEL_A_PC;
                sel_b = SEL_B_FOUR;
            end
            OPC_BRANCH: begin
                case (funct3)
                    F3_BEQ, F3_BNE:   alu_control = ALU_SUB;
                    F3_BLT, F3_BGE:   alu_control = ALU_SLT;
                    F3_BLTU, F3_BGEU: alu_control = ALU_SLTU;
                    default:          illegal     = 1'b1;
                endcase
                if (!illegal) begin
                    sel_a     = SEL_A_RS1;
                    sel_b     = SEL_B_RS2;
                    br_invert = branch_inverts(funct3);
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_issue.sv
// ID/EX issue register for the RV32I ALU: decodes, selects operands and presents them
// through a valid/ready stage with stall and flush. Optional counters: ALU_ISSUE_STATS_EN.
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_b5,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] operand_a,
    output logic [XLEN-1:0] operand_b,
    output logic [3:0]      alu_control,
`ifdef ALU_ISSUE_STATS_EN
    output logic [31:0]     stat_issued,
    output logic [31:0]     stat_stall,
`endif
    output logic            br_invert,
    output logic            illegal
);

    alu_op_t dec_op;
    sel_a_t  dec_sel_a;
    sel_b_t  dec_sel_b;
    logic    dec_inv;
    logic    dec_ill;

    logic [XLEN-1:0] mux_a;
    logic [XLEN-1:0] mux_b;
    logic            accept;

    logic            vld_p1;
    logic [XLEN-1:0] op_a_p1;
    logic [XLEN-1:0] op_b_p1;
    logic [3:0]      ctl_p1;
    logic            inv_p1;
    logic            ill_p1;

    alu_op_decode u_decode (
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7_b5   (funct7_b5),
        .alu_control (dec_op),
        .sel_a       (dec_sel_a),
        .sel_b       (dec_sel_b),
        .br_invert   (dec_inv),
        .illegal     (dec_ill)
    );

    always_comb begin
        mux_a = '0;
        case (dec_sel_a)
            SEL_A_RS1: mux_a = rs1_data;
            SEL_A_PC:  mux_a = pc;
            default:   mux_a = '0;
        endcase
    end

    always_comb begin
        mux_b = '0;
        case (dec_sel_b)
            SEL_B_RS2:  mux_b = rs2_data;
            SEL_B_IMM:  mux_b = imm;
            SEL_B_FOUR: mux_b = XLEN'(4);
            default:    mux_b = '0;
        endcase
    end

    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // ---- p1: ID/EX boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_p1 <= '0;
            op_b_p1 <= '0;
            ctl_p1  <= ALU_ADD;
            inv_p1  <= 1'b0;
            ill_p1  <= 1'b0;
        end else if (accept) begin
            op_a_p1 <= mux_a;
            op_b_p1 <= mux_b;
            ctl_p1  <= dec_op;
            inv_p1  <= dec_inv;
            ill_p1  <= dec_ill;
        end
    end

    assign out_valid   = vld_p1;
    assign operand_a   = op_a_p1;
    assign operand_b   = op_b_p1;
    assign alu_control = ctl_p1;
    assign br_invert   = inv_p1;
    assign illegal     = ill_p1;

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (vld_p1 && out_ready) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (vld_p1 && !out_ready) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
